// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter: latches one-cycle pulses into a pending register and
// presents enabled sources one at a time over a req/ack handshake, with post-ack holdoff.
module irq_arbiter #(
  parameter int unsigned   N        = 8,
  parameter int unsigned   ID_W     = 3,
  parameter int unsigned   HOLDOFF  = 2,
  parameter logic [N-1:0]  MASK_RST = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    irq_pulse_i,
  input  logic            mask_wr_i,
  input  logic [N-1:0]    mask_wdata_i,
  output logic [N-1:0]    irq_mask_o,
  output logic [N-1:0]    pending_o,
  output logic            irq_req_o,
  output logic [ID_W-1:0] irq_id_o,
  input  logic            irq_ack_i,
  output logic [N-1:0]    ovf_flags_o,
  input  logic            ovf_clr_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    ovf_q, ovf_d;
  logic [N-1:0]    mask_q, mask_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [N-1:0]    clr_vec;
  logic [N-1:0]    enabled;
  logic [ID_W-1:0] sel_id;
  logic            accept;

  assign accept  = (state_q == StIssue) && irq_ack_i;
  assign enabled = pending_q & mask_q;

  always_comb begin
    clr_vec = '0;
    if (accept) clr_vec[id_q] = 1'b1;
  end

  // Descending scan so the lowest set index is the last assignment to stick.
  always_comb begin
    sel_id = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (enabled[i]) sel_id = ID_W'(i);
    end
  end

  // A pulse overrides a same-cycle clear; overflow only counts if the bit stays pending.
  always_comb begin
    pending_d = (pending_q & ~clr_vec) | irq_pulse_i;
    ovf_d     = (ovf_clr_i ? '0 : ovf_q) | (irq_pulse_i & pending_q & ~clr_vec);
    mask_d    = mask_wr_i ? mask_wdata_i : mask_q;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|enabled) begin
          id_d    = sel_id;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (irq_ack_i) begin
          if (HOLDOFF == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StHold;
            cnt_d   = 8'(HOLDOFF);
          end
        end
      end
      StHold: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pending_q <= '0;
      ovf_q     <= '0;
      mask_q    <= MASK_RST;
      id_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      mask_q    <= mask_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
    end
  end

  assign irq_mask_o  = mask_q;
  assign pending_o   = pending_q;
  assign irq_req_o   = (state_q == StIssue);
  assign irq_id_o    = id_q;
  assign ovf_flags_o = ovf_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed self-checking bench for irq_arbiter with N=4, HOLDOFF=2.
module tb_irq_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned ID_W = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    irq_pulse;
  logic            mask_wr;
  logic [N-1:0]    mask_wdata;
  logic [N-1:0]    irq_mask;
  logic [N-1:0]    pending;
  logic            irq_req;
  logic [ID_W-1:0] irq_id;
  logic            irq_ack;
  logic [N-1:0]    ovf_flags;
  logic            ovf_clr;

  int checks = 0;
  int errors = 0;
  int req_seen;

  irq_arbiter #(
    .N        (N),
    .ID_W     (ID_W),
    .HOLDOFF  (2),
    .MASK_RST (4'b1001)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .irq_pulse_i  (irq_pulse),
    .mask_wr_i    (mask_wr),
    .mask_wdata_i (mask_wdata),
    .irq_mask_o   (irq_mask),
    .pending_o    (pending),
    .irq_req_o    (irq_req),
    .irq_id_o     (irq_id),
    .irq_ack_i    (irq_ack),
    .ovf_flags_o  (ovf_flags),
    .ovf_clr_i    (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs set afterwards are captured at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    irq_pulse  = '0;
    mask_wr    = 1'b0;
    mask_wdata = '0;
    irq_ack    = 1'b0;
    ovf_clr    = 1'b0;
    #3;
    chk("rst_mask", 32'(irq_mask), 32'h9);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_req", 32'(irq_req), 32'h0);
    chk("rst_id", 32'(irq_id), 32'h0);
    chk("rst_ovf", 32'(ovf_flags), 32'h0);
    step();
    rst = 1'b0;
    step();

    mask_wr = 1'b1; mask_wdata = 4'b1111;
    step();
    mask_wr = 1'b0;
    chk("mask_write", 32'(irq_mask), 32'hf);

    // Single pulse: pending at +1, request at +2
    irq_pulse = 4'b0100;
    step();
    irq_pulse = '0;
    chk("t1_pending", 32'(pending), 32'h4);
    chk("t1_req_early", 32'(irq_req), 32'h0);
    step();
    chk("t1_req", 32'(irq_req), 32'h1);
    chk("t1_id", 32'(irq_id), 32'h2);
    step();
    step();
    chk("t1_req_held", 32'(irq_req), 32'h1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("t1_req_drop", 32'(irq_req), 32'h0);
    chk("t1_pending_clr", 32'(pending), 32'h0);
    repeat (3) step();

    // Priority and holdoff gap
    irq_pulse = 4'b1010;
    step();
    irq_pulse = '0;
    chk("t2_pending", 32'(pending), 32'ha);
    step();
    chk("t2_req1", 32'(irq_req), 32'h1);
    chk("t2_id1", 32'(irq_id), 32'h1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("t2_req_a1", 32'(irq_req), 32'h0);
    chk("t2_pending_a1", 32'(pending), 32'h8);
    step();
    chk("t2_req_a2", 32'(irq_req), 32'h0);
    step();
    chk("t2_req_a3", 32'(irq_req), 32'h0);
    step();
    chk("t2_req_a4", 32'(irq_req), 32'h1);
    chk("t2_id_a4", 32'(irq_id), 32'h3);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("t2_pending_end", 32'(pending), 32'h0);
    chk("t2_id_hold", 32'(irq_id), 32'h3);
    repeat (3) step();

    // Masked source stays pending until unmasked
    mask_wr = 1'b1; mask_wdata = 4'b0000;
    step();
    mask_wr = 1'b0;
    irq_pulse = 4'b0001;
    step();
    irq_pulse = '0;
    chk("t3_pending", 32'(pending), 32'h1);
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (irq_req) req_seen++;
    end
    chk("t3_no_req", 32'(req_seen), 32'h0);
    mask_wr = 1'b1; mask_wdata = 4'b0001;
    step();
    mask_wr = 1'b0;
    chk("t3_req_w1", 32'(irq_req), 32'h0);
    step();
    chk("t3_req_w2", 32'(irq_req), 32'h1);
    chk("t3_id_w2", 32'(irq_id), 32'h0);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("t3_pending_clr", 32'(pending), 32'h0);
    repeat (3) step();

    // Overflow, ack colliding with a new pulse, overflow clear
    irq_pulse = 4'b0010;
    step();
    irq_pulse = '0;
    step();
    irq_pulse = 4'b0010;
    step();
    irq_pulse = '0;
    chk("t4_ovf", 32'(ovf_flags), 32'h2);
    chk("t4_pending", 32'(pending), 32'h2);
    mask_wr = 1'b1; mask_wdata = 4'b0010;
    step();
    mask_wr = 1'b0;
    step();
    chk("t4_req", 32'(irq_req), 32'h1);
    chk("t4_id", 32'(irq_id), 32'h1);
    irq_ack = 1'b1; irq_pulse = 4'b0010;
    step();
    irq_ack = 1'b0; irq_pulse = '0;
    chk("t4_pend_kept", 32'(pending), 32'h2);
    chk("t4_ovf_kept", 32'(ovf_flags), 32'h2);
    chk("t4_req_drop", 32'(irq_req), 32'h0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(ovf_flags), 32'h0);
    step();
    step();
    chk("t4_rereq", 32'(irq_req), 32'h1);
    chk("t4_reid", 32'(irq_id), 32'h1);

    // Masking the active source does not withdraw the request
    mask_wr = 1'b1; mask_wdata = 4'b0000;
    step();
    mask_wr = 1'b0;
    chk("t5_mask0", 32'(irq_mask), 32'h0);
    chk("t5_req_kept", 32'(irq_req), 32'h1);
    step();
    chk("t5_req_kept2", 32'(irq_req), 32'h1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("t5_req_drop", 32'(irq_req), 32'h0);
    chk("t5_pending", 32'(pending), 32'h0);

    // Ack held through HOLD and IDLE is ignored
    irq_pulse = 4'b0100; irq_ack = 1'b1;
    step();
    irq_pulse = '0;
    repeat (3) step();
    irq_ack = 1'b0;
    chk("t5_ack_ignored", 32'(pending), 32'h4);
    chk("t5_idle_req", 32'(irq_req), 32'h0);

    // Drain bit 2, then set up pending=1010 with a live request
    mask_wr = 1'b1; mask_wdata = 4'b0100;
    step();
    mask_wr = 1'b0;
    step();
    chk("t6_id2", 32'(irq_id), 32'h2);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    repeat (3) step();
    irq_pulse = 4'b1010; mask_wr = 1'b1; mask_wdata = 4'b1111;
    step();
    irq_pulse = '0; mask_wr = 1'b0;
    step();
    chk("t6_req", 32'(irq_req), 32'h1);
    chk("t6_pending", 32'(pending), 32'ha);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_req", 32'(irq_req), 32'h0);
    chk("t6_async_pend", 32'(pending), 32'h0);
    chk("t6_async_ovf", 32'(ovf_flags), 32'h0);
    chk("t6_async_mask", 32'(irq_mask), 32'h9);
    chk("t6_async_id", 32'(irq_id), 32'h0);
    step();
    rst = 1'b0;
    req_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (irq_req) req_seen++;
    end
    chk("t6_quiet", 32'(req_seen), 32'h0);
    irq_pulse = 4'b1000;
    step();
    irq_pulse = '0;
    step();
    chk("t6_new_req", 32'(irq_req), 32'h1);
    chk("t6_new_id", 32'(irq_id), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Collects one-cycle interrupt pulses from N sources and presents them one at a time to a single consumer (CPU/sequencer) over a req/ack handshake.
- Sources are typically the outputs of edge-forwarding synchronisers, already in the consumer's clock domain.
- Provides a pending register, an enable mask, fixed-priority selection and sticky per-source overflow flags for events lost while still pending.

Parameters:
- N, 8, number of interrupt sources (1..32).
- ID_W, 3, width of irq_id; must satisfy 2**ID_W >= N.
- HOLDOFF, 2, idle cycles forced after each ack before the next request (0..255).
- MASK_RST, {N{1'b0}}, reset value of irq_mask (1 = source enabled).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq_pulse  in  N  one-cycle event pulses, one bit per source.
- mask_wr  in  1  write strobe for irq_mask.
- mask_wdata  in  N  new mask value.
- irq_mask  out  N  current enable mask.
- pending  out  N  latched, unserviced events (independent of mask).
- irq_req  out  1  request to consumer.
- irq_id  out  ID_W  index of the requesting source; valid while irq_req=1.
- irq_ack  in  1  consumer acknowledge.
- ovf_flags  out  N  sticky: event arrived while the same source was already pending.
- ovf_clr  in  1  clears all ovf_flags.

Behaviour:
- Reset (async, immediate): pending=0, ovf_flags=0, irq_mask=MASK_RST, irq_req=0, irq_id=0, state=IDLE, holdoff counter=0. Reset asserted mid-handshake drops irq_req at once; in-flight events are lost.
- Pending:
  - irq_pulse[i]=1 sets pending[i] at the next edge, whether or not the source is masked.
  - pending[i] clears only on an accepted ack for irq_id=i.
  - Same-cycle ack-clear and new pulse on the same bit: the pulse wins, pending[i] stays 1, ovf not set.
- Overflow: irq_pulse[i]=1 while pending[i]=1, with no same-cycle clear of bit i, sets ovf_flags[i] at the next edge.
  - ovf_clr clears all flags.
  - A new overflow in the same cycle as ovf_clr: the set wins for that bit.
- Mask:
  - mask_wr=1 loads mask_wdata at the next edge.
  - Masked sources stay pending and are requested once unmasked.
  - Masking the currently requested source during ISSUE does not withdraw the request.
- State machine (IDLE, ISSUE, HOLD):
  - IDLE: if (pending & irq_mask) != 0, register irq_id = lowest set index, assert irq_req, go to ISSUE. Selection uses the registered pending value.
  - ISSUE: irq_req=1 and irq_id held stable. When irq_ack=1: clear pending[irq_id], irq_req=0 at the next edge, then go to HOLD with the counter loaded to HOLDOFF. If HOLDOFF=0, go straight to IDLE.
  - HOLD: decrement the counter each cycle; go to IDLE when it reaches 1. irq_req=0 throughout.
- Latency:
  - Pulse in cycle t → pending visible at t+1 → irq_req=1 at t+2 if the FSM is in IDLE.
  - Ack in cycle a → irq_req=0 at a+1 → earliest next irq_req at a+2+HOLDOFF.
- irq_ack outside ISSUE is ignored (no state change, no pending clear).
- Priority is fixed: lower index wins; no starvation protection beyond HOLDOFF.
- irq_id holds its last value when irq_req=0.

Test Plan:
- N=4, HOLDOFF=2, mask=4'b1111. Pulse bit 2 at cycle 10 → pending=4'b0100 at 11; irq_req=1, irq_id=2 at 12. Ack at 15 → irq_req=0 and pending=0 at 16.
- Simultaneous pulses on bits 3 and 1 → first irq_id=1. After ack, 2 holdoff cycles, then irq_id=3. Verify gap: ack at a, next irq_req rises at a+4.
- mask=4'b0000, pulse bit 0 → pending[0]=1, irq_req stays 0 for 20 cycles. Write mask=4'b0001 → irq_req=1, irq_id=0 two cycles after the write strobe.
- Pulse bit 1 twice while unserviced → ovf_flags=4'b0010, pending[1] still 1. Ack pulse coincident with a new bit-1 pulse → pending[1] stays 1, ovf unchanged. ovf_clr → ovf_flags=0.
- irq_ack asserted in IDLE/HOLD → no pending change. Mask the requested source during ISSUE → irq_req remains 1 until ack.
- Assert reset while irq_req=1 with pending=4'b1010 → irq_req, pending, ovf_flags all 0 without waiting for a clock edge; irq_mask=MASK_RST. After release, no request until a new pulse arrives.
